// File: rtl/uart_io.sv
// uart_io: 8N1 serial front end. Received bytes are strobed to the ID stage with an
// alternating operand flag; MEM-stage results are serialised with a one-deep pending buffer.
module uart_io #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       UART_RX,
  input  logic [7:0] result_data,
  input  logic       result_start,
  output logic [7:0] rx_data,
  output logic       flag,
  output logic       signal,
  output logic       UART_TX
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3
  } tx_state_t;

  logic          r_rx_meta, r_rxs;
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic [7:0]    r_rx_data, w_rx_data_nxt;
  logic          r_flag, w_flag_nxt;
  logic          r_signal, w_signal_nxt;
  logic          r_op_idx, w_op_idx_nxt;

  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_pend_v, w_pend_v_nxt;
  logic [7:0]    r_pend_d, w_pend_d_nxt;
  logic          r_tx, w_tx_line;
  logic          w_tx_done;

  assign rx_data = r_rx_data;
  assign flag    = r_flag;
  assign signal  = r_signal;
  assign UART_TX = r_tx;

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rxs     <= r_rx_meta;
    end
  end

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_flag     <= 1'b0;
      r_signal   <= 1'b0;
      r_op_idx   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_flag     <= w_flag_nxt;
      r_signal   <= w_signal_nxt;
      r_op_idx   <= w_op_idx_nxt;
    end
  end

  // RX next-state: start bit checked at half-bit, then data and stop sampled at bit centres.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_flag_nxt     = r_flag;
    w_signal_nxt   = 1'b0;
    w_op_idx_nxt   = r_op_idx;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rxs) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_START;
        end else begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_bit_nxt = 3'd0;
          if (!r_rxs) begin
            w_rx_state_nxt = RX_DATA;
          end else begin
            w_rx_state_nxt = RX_IDLE;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rxs, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nxt = RX_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt = '0;
          if (r_rxs) begin
            w_rx_data_nxt  = r_rx_shift;
            w_flag_nxt     = r_op_idx;
            w_signal_nxt   = 1'b1;
            w_op_idx_nxt   = ~r_op_idx;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            // Framing error: drop the byte and wait for the line to recover.
            w_rx_state_nxt = RX_WAIT_HIGH;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (r_rxs) begin
          w_rx_state_nxt = RX_IDLE;
        end else begin
          w_rx_state_nxt = RX_WAIT_HIGH;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  // TX state, datapath and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_pend_v   <= 1'b0;
      r_pend_d   <= 8'h00;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_pend_v   <= w_pend_v_nxt;
      r_pend_d   <= w_pend_d_nxt;
      r_tx       <= w_tx_line;
    end
  end

  assign w_tx_done = (r_tx_cnt == BIT_LAST);

  // TX next-state; the line level is registered, so UART_TX lags the state by one clock.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_pend_v_nxt   = r_pend_v;
    w_pend_d_nxt   = r_pend_d;
    w_tx_line      = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_line = 1'b1;
        if (result_start) begin
          w_tx_shift_nxt = result_data;
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_START;
        end else begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_done) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = 3'd0;
          w_tx_state_nxt = TX_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_done) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
          end else begin
            w_tx_bit_nxt = r_tx_bit + 3'd1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        w_tx_line = 1'b1;
        if (w_tx_done) begin
          w_tx_cnt_nxt = '0;
          // A request landing on the final stop clock is newer than any pending byte.
          if (result_start) begin
            w_tx_shift_nxt = result_data;
            w_pend_v_nxt   = 1'b0;
            w_tx_state_nxt = TX_START;
          end else if (r_pend_v) begin
            w_tx_shift_nxt = r_pend_d;
            w_pend_v_nxt   = 1'b0;
            w_tx_state_nxt = TX_START;
          end else begin
            w_tx_state_nxt = TX_IDLE;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
      end
    endcase
    if (result_start && (r_tx_state != TX_IDLE) && !((r_tx_state == TX_STOP) && w_tx_done)) begin
      w_pend_v_nxt = 1'b1;
      w_pend_d_nxt = result_data;
    end else begin
      w_pend_d_nxt = w_pend_d_nxt;
    end
  end

endmodule

// File: tb/tb_uart_io.sv
// Scoreboard bench for uart_io at 16 clocks per bit: stimulus pushes expectations,
// independent RX/TX monitors pop and compare whenever the DUT produces output.
module tb_uart_io;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       UART_RX;
  logic [7:0] result_data;
  logic       result_start;
  logic [7:0] rx_data;
  logic       flag;
  logic       signal;
  logic       UART_TX;

  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] d;
    logic       f;
    int         t;
  } rx_item_t;

  rx_item_t   rx_exp[$];
  logic [7:0] tx_exp[$];
  int         tx_starts[$];
  logic       exp_op = 1'b0;

  uart_io #(.CLK_FREQ(160), .BAUD(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .UART_RX      (UART_RX),
    .result_data  (result_data),
    .result_start (result_start),
    .rx_data      (rx_data),
    .flag         (flag),
    .signal       (signal),
    .UART_TX      (UART_TX)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_b, input logic good);
    rx_item_t it;
    if (good) begin
      it.d = b;
      it.f = exp_op;
      it.t = cyc;
      rx_exp.push_back(it);
      exp_op = ~exp_op;
    end
    UART_RX = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      wait_cyc(16);
    end
    UART_RX = stop_b;
    wait_cyc(16);
  endtask

  task automatic pulse_req(input logic [7:0] d);
    result_data  = d;
    result_start = 1'b1;
    wait_cyc(1);
    result_start = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tx"}, {31'd0, UART_TX}, 32'd1);
    check({tag, "_signal"}, {31'd0, signal}, 32'd0);
    check({tag, "_flag"}, {31'd0, flag}, 32'd0);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 reset_checks("midreset");
    exp_op = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
  endtask

  // RX monitor: every signal strobe must match the oldest expected byte.
  logic prev_sig = 1'b0;
  always @(negedge clk) begin
    rx_item_t it;
    int lat;
    if (!rst_n) begin
      prev_sig = 1'b0;
    end else begin
      if (signal) begin
        check("rx_single_cycle", {31'd0, prev_sig}, 32'd0);
        if (rx_exp.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL rx_unexpected: signal with rx_data=%h, none expected", rx_data);
        end else begin
          it = rx_exp.pop_front();
          lat = cyc - it.t;
          check("rx_data", {24'd0, rx_data}, {24'd0, it.d});
          check("rx_flag", {31'd0, flag}, {31'd0, it.f});
          check("rx_latency_in_window", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
        end
      end
      prev_sig = signal;
    end
  end

  // TX monitor: detect start edge, sample each bit at its centre against the queued byte.
  int         tm_phase = 0;
  int         tm_cnt = 0;
  logic       tm_have = 1'b0;
  logic [7:0] tm_byte = 8'h00;
  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      tm_phase = 0;
    end else if (tm_phase == 0) begin
      if (UART_TX == 1'b0) begin
        tm_phase = 1;
        tm_cnt = 0;
        tx_starts.push_back(cyc);
        tm_have = (tx_exp.size() != 0);
        if (tm_have) begin
          tm_byte = tx_exp[0];
        end else begin
          n_chk++;
          n_bad++;
          $display("FAIL tx_unexpected: frame started at cycle %0d, none expected", cyc);
        end
      end
    end else begin
      tm_cnt++;
      if (tm_cnt == 7) begin
        check("tx_start_bit", {31'd0, UART_TX}, 32'd0);
      end else if (tm_cnt > 7 && ((tm_cnt - 7) % 16) == 0) begin
        k = (tm_cnt - 7) / 16;
        if (k <= 8) begin
          if (tm_have) check("tx_data_bit", {31'd0, UART_TX}, {31'd0, tm_byte[k-1]});
        end else begin
          check("tx_stop_bit", {31'd0, UART_TX}, 32'd1);
          if (tm_have) void'(tx_exp.pop_front());
          tm_phase = 0;
        end
      end
    end
  end

  initial begin
    int c;
    int r;
    rst_n        = 1'b0;
    UART_RX      = 1'b1;
    result_start = 1'b0;
    result_data  = 8'h00;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 UART_RX = ~UART_RX;
      @(negedge clk);
      reset_checks("reset");
    end
    @(posedge clk);
    #1;
    UART_RX = 1'b1;
    rst_n   = 1'b1;
    wait_cyc(5);

    // Back-to-back frames; operand flag alternates.
    send_rx(8'h3C, 1'b1, 1'b1);
    send_rx(8'hA5, 1'b1, 1'b1);
    send_rx(8'h01, 1'b1, 1'b1);
    wait_cyc(40);
    do_reset();

    // Framing error followed by a good byte.
    send_rx(8'h55, 1'b0, 1'b0);
    wait_cyc(40);
    UART_RX = 1'b1;
    wait_cyc(20);
    send_rx(8'h12, 1'b1, 1'b1);
    wait_cyc(20);

    // Short glitch must not start a frame.
    UART_RX = 1'b0;
    wait_cyc(3);
    UART_RX = 1'b1;
    wait_cyc(30);
    send_rx(8'h7E, 1'b1, 1'b1);
    wait_cyc(20);

    // Single transmit with one-cycle start latency.
    tx_exp.push_back(8'hC3);
    c = cyc;
    pulse_req(8'hC3);
    wait_cyc(200);
    check("tx_frames_c3", tx_starts.size(), 32'd1);
    check("tx_latency", (tx_starts.size() > 0) ? tx_starts[0] : -1, c + 2);
    tx_starts.delete();

    // Pending buffer: 22 is overwritten by 33, which follows 11 with no gap.
    tx_exp.push_back(8'h11);
    tx_exp.push_back(8'h33);
    r = cyc;
    pulse_req(8'h11);
    wait_cyc(30);
    pulse_req(8'h22);
    wait_cyc(30);
    pulse_req(8'h33);
    while (cyc < r + 286) wait_cyc(1);
    #3 check("tx_pre_reset_low", {31'd0, UART_TX}, 32'd0);
    rst_n = 1'b0;
    #1 reset_checks("tx_reset");
    check("tx_frames_buf", tx_starts.size(), 32'd2);
    check("tx_start_11", (tx_starts.size() > 0) ? tx_starts[0] : -1, r + 2);
    check("tx_start_33", (tx_starts.size() > 1) ? tx_starts[1] : -1, r + 162);
    check("tx_left_33", tx_exp.size(), 32'd1);
    tx_exp.delete();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    check("tx_idle_after_reset", {31'd0, UART_TX}, 32'd1);

    check("rx_queue_empty", rx_exp.size(), 32'd0);
    check("tx_queue_empty", tx_exp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_io.md
# uart_io

Serial operand/result front end for the pipelined CPU. It receives 8N1 bytes on the UART line and presents each byte to the ID stage as `rx_data` with a one-cycle `signal` strobe. `flag` alternates to select which operand register the byte targets. It also serialises the 8-bit result that the MEM stage announces with `result_start`, and buffers one pending result while a transmission is in progress.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ/BAUD`, truncated, and must be ≥ 4.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `UART_RX`  in  1  serial input, idle high, asynchronous to `clk`.
- `result_data`  in  8  result byte from MEM; sampled only in cycles where `result_start`=1.
- `result_start`  in  1  single-cycle request to transmit `result_data`.
- `rx_data`  out  8  last correctly framed received byte; holds until the next good byte.
- `flag`  out  1  target operand of `rx_data`: 0 = operand1, 1 = operand2.
- `signal`  out  1  one-cycle strobe; `rx_data` and `flag` are new in this cycle.
- `UART_TX`  out  1  serial output, idle high.

## Operation
- Reset values:
  - `rx_data`=0, `flag`=0, `signal`=0, `UART_TX`=1.
  - Operand index = 0, pending buffer empty.
  - RX and TX state machines in IDLE.
  - Both RX synchroniser flops = 1.
- RX path:
  - `UART_RX` passes through a 2-flop synchroniser; only the synchronised value `rxs` is used.
  - RX FSM states and transitions:
    - IDLE: on `rxs`=0, clear the bit counter and go to START.
    - START: count `CLKS_PER_BIT/2` clocks, then sample. If `rxs`=0, go to DATA. If `rxs`=1, treat it as a glitch and return to IDLE.
    - DATA: sample every `CLKS_PER_BIT` clocks, 8 samples, LSB first, into a shift register, then go to STOP.
    - STOP: after `CLKS_PER_BIT` clocks, sample.
      - If `rxs`=1: load `rx_data`, drive `flag` = operand index, pulse `signal` for one cycle, toggle the operand index, go to IDLE.
      - If `rxs`=0 (framing error): discard the byte, no `signal`, operand index unchanged, go to WAIT_HIGH.
    - WAIT_HIGH: stay until `rxs`=1, then go to IDLE.
- TX path:
  - TX FSM states: IDLE, START, DATA, STOP. Each state lasts `CLKS_PER_BIT` clocks per bit. Data is sent LSB first, 8 bits, followed by a single stop bit of 1.
  - `result_start` in TX IDLE with no pending byte: latch `result_data` into the shift register and enter START on the next edge.
  - `result_start` while TX is busy: write `result_data` into the pending buffer. If the buffer is already full, the new byte overwrites the old one (newest wins).
  - End of STOP with the pending buffer full: move the pending byte into the shift register, clear pending, and go straight to START. No idle gap is inserted.
- RX and TX are fully independent. A byte received while transmitting is unaffected, and the reverse holds too.

## Timing
- `UART_TX` falls on the first clock edge after the edge that samples `result_start`=1 in IDLE, i.e. latency 1 cycle.
- Each TX bit lasts exactly `CLKS_PER_BIT` clocks, so a frame is `10*CLKS_PER_BIT` clocks.
- `signal` asserts `2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` clocks (±1) after the pin's falling start edge. This is the mid-stop-bit sample.
- `signal` is exactly one cycle wide and never asserts in two consecutive cycles.
- Back-to-back RX frames, where a start bit immediately follows the stop bit, must be received without loss.
- A `result_start` arriving in the same cycle that TX STOP completes with pending empty is a start request in IDLE. It must not be lost: it begins transmission with no gap, or at most 1 idle cycle.
- Asserting `rst_n` low mid-frame:
  - Immediately forces `UART_TX`=1, all outputs to their reset values, and the pending byte is dropped.
  - After release, RX requires a fresh falling edge before it starts a new frame.

## Test plan
Test parameters: `CLK_FREQ`=160, `BAUD`=10, so `CLKS_PER_BIT`=16.
- Reset: hold `rst_n`=0 for 5 cycles with `UART_RX` toggling → `UART_TX`=1, `signal`=0, `flag`=0, `rx_data`=0 throughout.
- Two RX frames 8'h3C then 8'hA5 → first `signal` pulse with `rx_data`=3C, `flag`=0; second pulse with `rx_data`=A5, `flag`=1; a third byte 8'h01 gives `flag`=0.
- Framing error: send 8'h55 with stop bit=0, hold the line low 40 clocks, then send 8'h12 → no pulse for 55; pulse for 12 with `flag`=0.
- Glitch: pulse `UART_RX` low for 3 clocks → no `signal`, RX back in IDLE, and the next frame 8'h7E is received correctly.
- TX: `result_start` with `result_data`=8'hC3 → `UART_TX` bits 0,1,1,0,0,0,0,1,1,1, each 16 clocks wide, starting 1 cycle after the request.
- TX buffering: request 8'h11, then 8'h22 and 8'h33 during the 8'h11 frame → frames 11 then 33 back to back, with 22 dropped; a reset issued mid-33 sets `UART_TX`=1 immediately.
